// File: rtl/fir_axil_engine.sv
// fir_axil_engine: AXI4-Lite slave FIR engine.
//   A write to SAMPLE_IN shifts the sample delay line and starts a sequential
//   multiply-accumulate, one tap per cycle. The accumulated sum is saturated
//   to 32 bits and latched into RESULT; DONE is then set and can raise irq.
// Register map (byte address, low two bits ignored):
//   0x00 CTRL      RW  b1 IRQ_EN, b0 CLR (self-clearing, reads 0)
//   0x04 STATUS        b0 BUSY (RO), b1 DONE (W1C)
//   0x08 SAMPLE_IN WO  reads 0
//   0x0C RESULT    RO
//   0x40+4k COEF[k] RW, k < NUM_TAPS, read back sign-extended
//   Any other address answers SLVERR with RDATA = 0 and has no effect.
// Ports:
//   ACLK, ARESET     clock, synchronous active-high reset
//   S_AXI_AW*/W*/B*  AXI4-Lite write channels (AWPROT ignored)
//   S_AXI_AR*/R*     AXI4-Lite read channels (ARPROT ignored)
//   irq              registered DONE & IRQ_EN
module fir_axil_engine #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 8,
  parameter int NUM_TAPS = 8,
  parameter int SAMPLE_W = 16
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [ADDR_W-1:0] S_AXI_AWADDR,
  input  logic [2:0]        S_AXI_AWPROT,
  input  logic              S_AXI_AWVALID,
  output logic              S_AXI_AWREADY,
  input  logic [DATA_W-1:0] S_AXI_WDATA,
  input  logic [3:0]        S_AXI_WSTRB,
  input  logic              S_AXI_WVALID,
  output logic              S_AXI_WREADY,
  output logic [1:0]        S_AXI_BRESP,
  output logic              S_AXI_BVALID,
  input  logic              S_AXI_BREADY,
  input  logic [ADDR_W-1:0] S_AXI_ARADDR,
  input  logic [2:0]        S_AXI_ARPROT,
  input  logic              S_AXI_ARVALID,
  output logic              S_AXI_ARREADY,
  output logic [DATA_W-1:0] S_AXI_RDATA,
  output logic [1:0]        S_AXI_RRESP,
  output logic              S_AXI_RVALID,
  input  logic              S_AXI_RREADY,
  output logic              irq
);
  localparam int TAP_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int ACC_W = 2*SAMPLE_W + $clog2(NUM_TAPS);
  localparam int IDX_W = ADDR_W - 2;
  localparam logic [IDX_W-1:0] IDX_CTRL = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_STAT = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_SAMP = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_RES  = IDX_W'(3);
  localparam logic [IDX_W-1:0] IDX_COEF = IDX_W'(16);
  localparam logic [IDX_W-1:0] IDX_CEND = IDX_W'(16 + NUM_TAPS);
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_WB} state_t;

  // ---------------- write channel ----------------
  logic             up_q;          // readies stay low during and just after reset
  logic             aw_held_q, w_held_q, bvalid_q;
  logic [1:0]       bresp_q;
  logic [IDX_W-1:0] waddr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;
  logic             aw_hs, w_hs, b_hs, commit, wr_err;

  assign S_AXI_AWREADY = up_q && !aw_held_q && !bvalid_q;
  assign S_AXI_WREADY  = up_q && !w_held_q && !bvalid_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
  assign b_hs   = bvalid_q && S_AXI_BREADY;
  // Holding regs stay full until the B handshake, so this fires once per write.
  assign commit = aw_held_q && w_held_q && !bvalid_q;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      up_q      <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      up_q <= 1'b1;
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        waddr_q   <= S_AXI_AWADDR[ADDR_W-1:2];
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        wdata_q  <= S_AXI_WDATA;
        wstrb_q  <= S_AXI_WSTRB;
      end
      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_err ? 2'b10 : 2'b00;
      end else if (b_hs) begin
        bvalid_q  <= 1'b0;
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
      end
    end
  end

  // ---------------- write decode ----------------
  state_t           state_q, state_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic             busy, mac_en, wb;
  logic             is_ctrl, is_stat, is_samp, is_res, is_coef;
  logic             ctrl_we, clr, samp_go, coef_we;
  logic [IDX_W-1:0] wk_full;
  logic [TAP_W-1:0] wk;
  logic [31:0]      wmask, coef_old, coef_new;

  logic [NUM_TAPS-1:0][SAMPLE_W-1:0] coef_q, dl_q;

  assign busy    = (state_q != S_IDLE);
  assign is_ctrl = (waddr_q == IDX_CTRL);
  assign is_stat = (waddr_q == IDX_STAT);
  assign is_samp = (waddr_q == IDX_SAMP);
  assign is_res  = (waddr_q == IDX_RES);
  assign is_coef = (waddr_q >= IDX_COEF) && (waddr_q < IDX_CEND);
  assign wr_err  = !(is_ctrl || is_stat || is_samp || is_res || is_coef) ||
                   ((is_samp || is_coef) && busy);

  // IRQ_EN and CLR both live in byte 0, so that strobe gates the whole register.
  assign ctrl_we = commit && is_ctrl && wstrb_q[0];
  assign clr     = ctrl_we && wdata_q[0];
  assign samp_go = commit && is_samp && !busy;
  assign coef_we = commit && is_coef && !busy;

  // Coefficient byte merge works on the sign-extended 32-bit view, so a
  // partial write sees exactly what a read would have returned.
  assign wk_full  = waddr_q - IDX_COEF;
  assign wk       = wk_full[TAP_W-1:0];
  assign wmask    = {{8{wstrb_q[3]}}, {8{wstrb_q[2]}}, {8{wstrb_q[1]}}, {8{wstrb_q[0]}}};
  assign coef_old = 32'($signed(coef_q[wk]));
  assign coef_new = (coef_old & ~wmask) | (wdata_q & wmask);

  // ---------------- MAC FSM ----------------
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= S_IDLE;
      tap_q   <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    mac_en  = 1'b0;
    wb      = 1'b0;
    case (state_q)
      S_IDLE: if (samp_go) begin
        state_d = S_MAC;
        tap_d   = '0;
      end
      S_MAC: begin
        mac_en = 1'b1;
        if (tap_q == LAST_TAP) state_d = S_WB;
        else                   tap_d   = tap_q + 1'b1;
      end
      S_WB: begin
        wb      = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (clr) begin
      state_d = S_IDLE;
      tap_d   = '0;
    end
  end

  // ---------------- datapath ----------------
  logic signed [2*SAMPLE_W-1:0] prod;
  logic signed [ACC_W-1:0]      acc_q, acc_d;
  logic [31:0]                  sat_res, result_q;
  logic                         done_q, done_d, irq_en_q, irq_q;

  assign prod = (2*SAMPLE_W)'($signed(dl_q[tap_q])) * (2*SAMPLE_W)'($signed(coef_q[tap_q]));

  always_comb begin
    acc_d = acc_q;
    if (clr || samp_go) acc_d = '0;
    else if (mac_en)    acc_d = acc_q + ACC_W'(prod);
  end

  if (ACC_W > 32) begin : g_sat
    logic [ACC_W-32:0] top;
    logic              ovf;
    assign top     = acc_q[ACC_W-1:31];
    assign ovf     = !((&top) || !(|top));
    assign sat_res = !ovf ? acc_q[31:0] : (acc_q[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF);
  end else begin : g_ext
    assign sat_res = 32'(acc_q);
  end

  // Set at writeback wins over a W1C in the same cycle.
  always_comb begin
    done_d = done_q;
    if (commit && is_stat && wdata_q[1]) done_d = 1'b0;
    if (samp_go)                         done_d = 1'b0;
    if (wb && !clr)                      done_d = 1'b1;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      coef_q   <= '0;
      dl_q     <= '0;
      acc_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      done_q <= done_d;
      irq_q  <= done_q && irq_en_q;
      if (ctrl_we) irq_en_q <= wdata_q[1];
      if (coef_we) coef_q[wk] <= coef_new[SAMPLE_W-1:0];
      if (clr) begin
        dl_q <= '0;
      end else if (samp_go) begin
        dl_q[0] <= wdata_q[SAMPLE_W-1:0];
        for (int i = 1; i < NUM_TAPS; i++) dl_q[i] <= dl_q[i-1];
      end
      if (wb && !clr) result_q <= sat_res;
    end
  end

  assign irq = irq_q;

  // ---------------- read channel ----------------
  logic             rvalid_q, ar_hs, rerr_d;
  logic [1:0]       rresp_q;
  logic [31:0]      rdata_q, rdata_d;
  logic [IDX_W-1:0] ridx, rk_full;

  assign S_AXI_ARREADY = up_q && !rvalid_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign ar_hs   = S_AXI_ARVALID && S_AXI_ARREADY;
  assign ridx    = S_AXI_ARADDR[ADDR_W-1:2];
  assign rk_full = ridx - IDX_COEF;

  always_comb begin
    rdata_d = '0;
    rerr_d  = 1'b0;
    if      (ridx == IDX_CTRL) rdata_d = {30'b0, irq_en_q, 1'b0};
    else if (ridx == IDX_STAT) rdata_d = {30'b0, done_q, busy};
    else if (ridx == IDX_SAMP) rdata_d = '0;
    else if (ridx == IDX_RES)  rdata_d = result_q;
    else if ((ridx >= IDX_COEF) && (ridx < IDX_CEND))
      rdata_d = 32'($signed(coef_q[rk_full[TAP_W-1:0]]));
    else rerr_d = 1'b1;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= 2'b00;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rdata_d;
      rresp_q  <= rerr_d ? 2'b10 : 2'b00;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0],
                       S_AXI_ARADDR[1:0], coef_new[31:SAMPLE_W], wk_full, rk_full};
endmodule
